// File: rtl/spu_decode_stage.sv
// rtl/spu_decode_stage.sv - SPU instruction decode stage with output register and skid buffer
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous kill of output register and skid buffer
//   in_valid/in_ready     fetch-side handshake; in_inst carries the 32-bit word
//                         (SPU bit 0 is in_inst[31])
//   out_valid/out_ready   execution-side handshake for the decoded packet
//   out_opcode            right-aligned 11-bit opcode value, 0 when illegal
//   out_fmt               0=RR 1=RI7 2=RI10 3=RI16 4=RI18 7=illegal
//   out_rt/ra/rb          register fields (zero where the format has none)
//   out_imm               extended immediate (zero for RR and illegal)
//   out_illegal           word matched no table entry
//   cnt_inst/cnt_illegal  saturating counts of delivered / delivered-illegal packets

module spu_decode_stage #(
    parameter int INST_W = 32,
    parameter int REG_AW = 7,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [10:0]       out_opcode,
    output logic [2:0]        out_fmt,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_ra,
    output logic [REG_AW-1:0] out_rb,
    output logic [31:0]       out_imm,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  cnt_inst,
    output logic [CNT_W-1:0]  cnt_illegal
);

    // Format codes
    localparam logic [2:0] FMT_RR   = 3'd0;
    localparam logic [2:0] FMT_RI7  = 3'd1;
    localparam logic [2:0] FMT_RI10 = 3'd2;
    localparam logic [2:0] FMT_RI16 = 3'd3;
    localparam logic [2:0] FMT_RI18 = 3'd4;
    localparam logic [2:0] FMT_ILL  = 3'd7;

    // RR opcodes (11-bit)
    localparam logic [10:0] OP_A     = 11'h0C0;
    localparam logic [10:0] OP_AH    = 11'h0C8;
    localparam logic [10:0] OP_SF    = 11'h040;
    localparam logic [10:0] OP_SFH   = 11'h048;
    localparam logic [10:0] OP_AND   = 11'h0C1;
    localparam logic [10:0] OP_ANDC  = 11'h2C1;
    localparam logic [10:0] OP_OR    = 11'h041;
    localparam logic [10:0] OP_ORC   = 11'h2C9;
    localparam logic [10:0] OP_XOR   = 11'h241;
    localparam logic [10:0] OP_NAND  = 11'h0C9;
    localparam logic [10:0] OP_NOR   = 11'h049;
    localparam logic [10:0] OP_EQV   = 11'h249;
    localparam logic [10:0] OP_CEQ   = 11'h3C0;
    localparam logic [10:0] OP_CEQH  = 11'h3C8;
    localparam logic [10:0] OP_CGT   = 11'h240;
    localparam logic [10:0] OP_CGTH  = 11'h248;
    localparam logic [10:0] OP_CLGT  = 11'h2C0;
    localparam logic [10:0] OP_SHL   = 11'h05B;
    localparam logic [10:0] OP_SHLH  = 11'h05F;
    localparam logic [10:0] OP_ROT   = 11'h058;
    localparam logic [10:0] OP_ROTH  = 11'h05C;
    // RI7 opcode (11-bit)
    localparam logic [10:0] OP_SHLHI = 11'h07F;
    // RI16 opcode (9-bit, right-aligned)
    localparam logic [10:0] OP_ILH   = 11'h083;
    // RI10 opcodes (8-bit, right-aligned)
    localparam logic [10:0] OP_AHI   = 11'h01D;
    localparam logic [10:0] OP_AI    = 11'h01C;
    localparam logic [10:0] OP_SFHI  = 11'h00D;
    localparam logic [10:0] OP_SFI   = 11'h00C;
    localparam logic [10:0] OP_ANDI  = 11'h014;
    localparam logic [10:0] OP_ANDHI = 11'h015;
    localparam logic [10:0] OP_ANDBI = 11'h016;
    localparam logic [10:0] OP_ORI   = 11'h004;
    localparam logic [10:0] OP_ORHI  = 11'h005;
    localparam logic [10:0] OP_ORBI  = 11'h006;
    localparam logic [10:0] OP_XORI  = 11'h044;
    localparam logic [10:0] OP_XORHI = 11'h045;
    localparam logic [10:0] OP_XORBI = 11'h046;
    localparam logic [10:0] OP_CEQI  = 11'h07C;
    localparam logic [10:0] OP_CEQHI = 11'h07D;
    localparam logic [10:0] OP_CGTI  = 11'h04C;
    localparam logic [10:0] OP_CGTHI = 11'h04D;
    localparam logic [10:0] OP_CGTBI = 11'h04E;
    // RI18 opcode (7-bit, right-aligned)
    localparam logic [10:0] OP_ILA   = 11'h021;

    typedef struct packed {
        logic [10:0]       opcode;
        logic [2:0]        fmt;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [31:0]       imm;
        logic              illegal;
    } pkt_t;

    pkt_t        dec_pkt;
    pkt_t        out_pkt;
    pkt_t        skid_pkt;
    logic        skid_full;
    logic [10:0] d_op;
    logic [2:0]  d_fmt;
    logic        d_hit;
    logic        in_fire;
    logic        out_fire;
    logic        out_free;

    // Opcode match. Each width is tried in order, longest first; a code
    // only matches at its own width because each case compares a
    // zero-extended slice of exactly that width.
    always_comb begin
        d_op  = 11'h000;
        d_fmt = FMT_ILL;
        d_hit = 1'b1;
        case (in_inst[31:21])
            OP_A, OP_AH, OP_SF, OP_SFH, OP_AND, OP_ANDC, OP_OR, OP_ORC,
            OP_XOR, OP_NAND, OP_NOR, OP_EQV, OP_CEQ, OP_CEQH, OP_CGT,
            OP_CGTH, OP_CLGT, OP_SHL, OP_SHLH, OP_ROT, OP_ROTH: begin
                d_op  = in_inst[31:21];
                d_fmt = FMT_RR;
            end
            OP_SHLHI: begin
                d_op  = in_inst[31:21];
                d_fmt = FMT_RI7;
            end
            default: d_hit = 1'b0;
        endcase

        if (!d_hit) begin
            d_hit = 1'b1;
            case ({2'b00, in_inst[31:23]})
                OP_ILH: begin
                    d_op  = {2'b00, in_inst[31:23]};
                    d_fmt = FMT_RI16;
                end
                default: d_hit = 1'b0;
            endcase
        end

        if (!d_hit) begin
            d_hit = 1'b1;
            case ({3'b000, in_inst[31:24]})
                OP_AHI, OP_AI, OP_SFHI, OP_SFI, OP_ANDI, OP_ANDHI, OP_ANDBI,
                OP_ORI, OP_ORHI, OP_ORBI, OP_XORI, OP_XORHI, OP_XORBI,
                OP_CEQI, OP_CEQHI, OP_CGTI, OP_CGTHI, OP_CGTBI: begin
                    d_op  = {3'b000, in_inst[31:24]};
                    d_fmt = FMT_RI10;
                end
                default: d_hit = 1'b0;
            endcase
        end

        if (!d_hit) begin
            case ({4'b0000, in_inst[31:25]})
                OP_ILA: begin
                    d_op  = {4'b0000, in_inst[31:25]};
                    d_fmt = FMT_RI18;
                end
                default: begin
                    d_op  = 11'h000;
                    d_fmt = FMT_ILL;
                end
            endcase
        end
    end

    // Field extraction by format; unused fields stay zero so downstream
    // never sees stray register numbers on formats that lack them.
    always_comb begin
        dec_pkt        = '0;
        dec_pkt.opcode = d_op;
        dec_pkt.fmt    = d_fmt;
        case (d_fmt)
            FMT_RR: begin
                dec_pkt.rt = in_inst[6:0];
                dec_pkt.ra = in_inst[13:7];
                dec_pkt.rb = in_inst[20:14];
            end
            FMT_RI7: begin
                dec_pkt.rt  = in_inst[6:0];
                dec_pkt.ra  = in_inst[13:7];
                dec_pkt.imm = {{25{in_inst[20]}}, in_inst[20:14]};
            end
            FMT_RI10: begin
                dec_pkt.rt  = in_inst[6:0];
                dec_pkt.ra  = in_inst[13:7];
                dec_pkt.imm = {{22{in_inst[23]}}, in_inst[23:14]};
            end
            FMT_RI16: begin
                dec_pkt.rt  = in_inst[6:0];
                dec_pkt.imm = {{16{in_inst[22]}}, in_inst[22:7]};
            end
            FMT_RI18: begin
                dec_pkt.rt  = in_inst[6:0];
                dec_pkt.imm = {14'b0, in_inst[24:7]};
            end
            default: begin
                dec_pkt.opcode  = 11'h000;
                dec_pkt.fmt     = FMT_ILL;
                dec_pkt.illegal = 1'b1;
            end
        endcase
    end

    // in_ready depends only on the skid flop, so it is registered and does
    // not combinationally follow out_ready.
    assign in_ready = ~skid_full;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    // Output register can take a new packet this cycle.
    assign out_free = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pkt   <= '0;
            skid_full <= 1'b0;
            skid_pkt  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_pkt   <= '0;
            skid_full <= 1'b0;
        end else if (out_free) begin
            // Skid entry is older than anything at the input, so it goes first.
            // in_ready is low whenever the skid is full, so no input is taken then.
            if (skid_full) begin
                out_pkt   <= skid_pkt;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else if (in_fire) begin
                out_pkt   <= dec_pkt;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_pkt  <= dec_pkt;
            skid_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_inst    <= '0;
            cnt_illegal <= '0;
        end else if (out_fire) begin
            if (cnt_inst != '1) begin
                cnt_inst <= cnt_inst + CNT_W'(1);
            end
            if (out_pkt.illegal && (cnt_illegal != '1)) begin
                cnt_illegal <= cnt_illegal + CNT_W'(1);
            end
        end
    end

    assign out_opcode  = out_pkt.opcode;
    assign out_fmt     = out_pkt.fmt;
    assign out_rt      = out_pkt.rt;
    assign out_ra      = out_pkt.ra;
    assign out_rb      = out_pkt.rb;
    assign out_imm     = out_pkt.imm;
    assign out_illegal = out_pkt.illegal;

endmodule
